scoreboard_hazard: RTL and testbench

- Parametrised issue-stage hazard unit for the next-generation pipelined RV32 core. The current five-stage pipeline has no interlocks; this block adds them.
- Tracks every in-flight register write with a per-register countdown scoreboard that supports variable writeback latency (ALU, load, multi-cycle ops).
- Raises stall on RAW and WAW hazards and flags operands that are ready only through the bypass path.
- Sits between ID (issue request) and the ID/EX pipeline register; EX/MEM/WB forwarding muxes consume its forward flags.

---
 rtl/scoreboard_hazard_if.sv | 35 +++
 rtl/scoreboard_hazard.sv | 89 ++++++++
 tb/tb_scoreboard_hazard.sv | 272 +++++++++++++++++++++++++++
 3 files changed

// File: rtl/scoreboard_hazard_if.sv
// Issue-side bundle between the ID stage and the hazard scoreboard.
// master = ID / pipeline control, slave = scoreboard_hazard.
interface scoreboard_hazard_if #(
  parameter int NREG = 32,
  parameter int AW   = 5,
  parameter int CW   = 3
);
  logic            issue_valid;
  logic [AW-1:0]   issue_rs1;
  logic [AW-1:0]   issue_rs2;
  logic            issue_use_rs1;
  logic            issue_use_rs2;
  logic            issue_we;
  logic [AW-1:0]   issue_rd;
  logic [CW-1:0]   issue_lat;
  logic            flush;
  logic            stall;
  logic            issue_fire;
  logic            fwd1;
  logic            fwd2;
  logic [NREG-1:0] busy_mask;
  logic [31:0]     stall_cnt;

  modport master (
    output issue_valid, issue_rs1, issue_rs2, issue_use_rs1, issue_use_rs2,
           issue_we, issue_rd, issue_lat, flush,
    input  stall, issue_fire, fwd1, fwd2, busy_mask, stall_cnt
  );

  modport slave (
    input  issue_valid, issue_rs1, issue_rs2, issue_use_rs1, issue_use_rs2,
           issue_we, issue_rd, issue_lat, flush,
    output stall, issue_fire, fwd1, fwd2, busy_mask, stall_cnt
  );
endinterface

// File: rtl/scoreboard_hazard.sv
// Issue-stage interlock: per-register writeback countdown scoreboard that
// raises stall on RAW/WAW hazards and flags operands served by the bypass.
module scoreboard_hazard #(
  parameter int NREG    = 32,
  parameter int AW      = 5,
  parameter int MAX_LAT = 4,
  parameter int CW      = 3,
  parameter int FWD_EN  = 1
) (
  input logic                clk,
  input logic                reset,
  scoreboard_hazard_if.slave sb
);

  localparam logic [CW-1:0] MAX_LAT_C = CW'(MAX_LAT);
  localparam logic [CW-1:0] ONE       = CW'(1);
  localparam bit            FWD       = (FWD_EN != 0);

  logic [CW-1:0]   cnt [NREG];
  logic [CW-1:0]   eff_lat;
  logic [CW-1:0]   cnt_rs1, cnt_rs2, cnt_rd;
  logic            rdy1, rdy2;
  logic            raw, waw;
  logic            stall, fire;
  logic [NREG-1:0] busy;
  logic [31:0]     stall_cnt_q;

  // NOTE: every variable assigned in always_comb gets a default first, so no
  // path through the block can leave it unassigned and infer a latch.
  always_comb begin
    eff_lat = sb.issue_lat;
    if (sb.issue_lat == '0)
      eff_lat = ONE;
    else if (sb.issue_lat > MAX_LAT_C)
      eff_lat = MAX_LAT_C;
  end

  assign cnt_rs1 = cnt[sb.issue_rs1];
  assign cnt_rs2 = cnt[sb.issue_rs2];
  assign cnt_rd  = cnt[sb.issue_rd];

  // A source is usable when its producer is done, or one cycle from done
  // and the bypass network can deliver it.
  assign rdy1 = (cnt_rs1 == '0) || (FWD && cnt_rs1 == ONE);
  assign rdy2 = (cnt_rs2 == '0) || (FWD && cnt_rs2 == ONE);

  assign raw = (sb.issue_use_rs1 && !rdy1) || (sb.issue_use_rs2 && !rdy2);
  assign waw = sb.issue_we && (sb.issue_rd != '0) && (cnt_rd > eff_lat);

  assign stall = sb.issue_valid && !sb.flush && (raw || waw);
  assign fire  = sb.issue_valid && !sb.flush && !stall;

  always_comb begin
    busy = '0;
    for (int r = 0; r < NREG; r++)
      busy[r] = (cnt[r] != '0);
  end

  assign sb.stall      = stall;
  assign sb.issue_fire = fire;
  assign sb.fwd1       = sb.issue_valid && sb.issue_use_rs1 && FWD && (cnt_rs1 == ONE);
  assign sb.fwd2       = sb.issue_valid && sb.issue_use_rs2 && FWD && (cnt_rs2 == ONE);
  assign sb.busy_mask  = busy;
  assign sb.stall_cnt  = stall_cnt_q;

  // NOTE: the counter array is flip-flops, not a RAM, so clearing every entry
  // on reset is both legal and required for a defined scoreboard state.
  // NOTE: sequential state uses non-blocking assignments only, so every flop
  // samples pre-edge values regardless of statement order.
  always_ff @(posedge clk) begin
    if (reset) begin
      for (int r = 0; r < NREG; r++)
        cnt[r] <= '0;
      stall_cnt_q <= '0;
    end else begin
      cnt[0] <= '0;
      // A new issue to r overrides the decrement of r's older write.
      for (int r = 1; r < NREG; r++) begin
        if (fire && sb.issue_we && (sb.issue_rd == AW'(r)))
          cnt[r] <= eff_lat;
        else if (cnt[r] != '0)
          cnt[r] <= cnt[r] - ONE;
      end
      if (stall && (stall_cnt_q != '1))
        stall_cnt_q <= stall_cnt_q + 32'd1;
    end
  end

endmodule

// File: tb/tb_scoreboard_hazard.sv
// Bench for scoreboard_hazard: a bypass and a no-bypass instance share one
// stimulus stream and are checked every cycle against a timestamp model.
module tb_scoreboard_hazard;
  localparam int NREG    = 32;
  localparam int AW      = 5;
  localparam int CW      = 3;
  localparam int MAX_LAT = 4;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic          reset;
  logic          v_valid, v_use1, v_use2, v_we, v_flush;
  logic [AW-1:0] v_rs1, v_rs2, v_rd;
  logic [CW-1:0] v_lat;

  scoreboard_hazard_if #(.NREG(NREG), .AW(AW), .CW(CW)) sb0_if ();
  scoreboard_hazard_if #(.NREG(NREG), .AW(AW), .CW(CW)) sb1_if ();

  assign sb0_if.issue_valid = v_valid;  assign sb1_if.issue_valid = v_valid;
  assign sb0_if.issue_rs1 = v_rs1;      assign sb1_if.issue_rs1 = v_rs1;
  assign sb0_if.issue_rs2 = v_rs2;      assign sb1_if.issue_rs2 = v_rs2;
  assign sb0_if.issue_use_rs1 = v_use1; assign sb1_if.issue_use_rs1 = v_use1;
  assign sb0_if.issue_use_rs2 = v_use2; assign sb1_if.issue_use_rs2 = v_use2;
  assign sb0_if.issue_we = v_we;        assign sb1_if.issue_we = v_we;
  assign sb0_if.issue_rd = v_rd;        assign sb1_if.issue_rd = v_rd;
  assign sb0_if.issue_lat = v_lat;      assign sb1_if.issue_lat = v_lat;
  assign sb0_if.flush = v_flush;        assign sb1_if.flush = v_flush;

  scoreboard_hazard #(.NREG(NREG), .AW(AW), .MAX_LAT(MAX_LAT), .CW(CW), .FWD_EN(1))
    dut0 (.clk(clk), .reset(reset), .sb(sb0_if.slave));
  scoreboard_hazard #(.NREG(NREG), .AW(AW), .MAX_LAT(MAX_LAT), .CW(CW), .FWD_EN(0))
    dut1 (.clk(clk), .reset(reset), .sb(sb1_if.slave));

  logic            o_stall [2];
  logic            o_fire  [2];
  logic            o_fwd1  [2];
  logic            o_fwd2  [2];
  logic [NREG-1:0] o_busy  [2];
  logic [31:0]     o_scnt  [2];

  assign o_stall[0] = sb0_if.stall;      assign o_stall[1] = sb1_if.stall;
  assign o_fire[0]  = sb0_if.issue_fire; assign o_fire[1]  = sb1_if.issue_fire;
  assign o_fwd1[0]  = sb0_if.fwd1;       assign o_fwd1[1]  = sb1_if.fwd1;
  assign o_fwd2[0]  = sb0_if.fwd2;       assign o_fwd2[1]  = sb1_if.fwd2;
  assign o_busy[0]  = sb0_if.busy_mask;  assign o_busy[1]  = sb1_if.busy_mask;
  assign o_scnt[0]  = sb0_if.stall_cnt;  assign o_scnt[1]  = sb1_if.stall_cnt;

  int n_checks = 0;
  int n_pass   = 0;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h", name, act, exp);
  endtask

  // Model: each register remembers the absolute cycle its result completes;
  // the remaining latency is simply that deadline minus the current cycle.
  // Instance 0 has bypass, instance 1 does not.
  longint now_c = 0;
  longint done_at [2][NREG];
  longint m_scnt  [2];
  bit     chk_en  = 1'b0;

  function automatic int rem(input int k, input int r);
    return (done_at[k][r] > now_c) ? int'(done_at[k][r] - now_c) : 0;
  endfunction

  function automatic int eff();
    int l = int'(v_lat);
    if (l == 0) return 1;
    return (l > MAX_LAT) ? MAX_LAT : l;
  endfunction

  function automatic bit rdy(input int k, input int r);
    int c = rem(k, r);
    return (c == 0) || (k == 0 && c == 1);
  endfunction

  function automatic bit m_stall(input int k);
    bit raw, waw;
    raw = (v_use1 && !rdy(k, int'(v_rs1))) || (v_use2 && !rdy(k, int'(v_rs2)));
    waw = v_we && (v_rd != 0) && (rem(k, int'(v_rd)) > eff());
    return v_valid && !v_flush && (raw || waw);
  endfunction

  function automatic bit m_fire(input int k);
    return v_valid && !v_flush && !m_stall(k);
  endfunction

  function automatic bit m_fwd(input int k, input logic use_r, input int r);
    return v_valid && use_r && (k == 0) && (rem(k, r) == 1);
  endfunction

  function automatic logic [NREG-1:0] m_busy(input int k);
    logic [NREG-1:0] b = '0;
    for (int r = 0; r < NREG; r++) b[r] = (rem(k, r) != 0);
    return b;
  endfunction

  always @(posedge clk) begin
    for (int k = 0; k < 2; k++) begin
      if (reset) begin
        for (int r = 0; r < NREG; r++) done_at[k][r] = 0;
        m_scnt[k] = 0;
      end else begin
        if (m_stall(k) && m_scnt[k] != 64'hFFFF_FFFF) m_scnt[k]++;
        if (m_fire(k) && v_we && v_rd != 0) done_at[k][v_rd] = now_c + 1 + eff();
      end
    end
    now_c++;
    if (reset) chk_en = 1'b1;
  end

  always @(negedge clk) begin
    if (chk_en) begin
      for (int k = 0; k < 2; k++) begin
        check($sformatf("stall[%0d]", k), 64'(o_stall[k]), 64'(m_stall(k)));
        check($sformatf("fire[%0d]", k), 64'(o_fire[k]), 64'(m_fire(k)));
        check($sformatf("fwd1[%0d]", k), 64'(o_fwd1[k]), 64'(m_fwd(k, v_use1, int'(v_rs1))));
        check($sformatf("fwd2[%0d]", k), 64'(o_fwd2[k]), 64'(m_fwd(k, v_use2, int'(v_rs2))));
        check($sformatf("busy[%0d]", k), 64'(o_busy[k]), 64'(m_busy(k)));
        check($sformatf("scnt[%0d]", k), 64'(o_scnt[k]), 64'(m_scnt[k]));
      end
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic drive(input logic valid, input int rs1, input logic use1, input int rs2,
                       input logic use2, input logic we, input int rd, input int lat,
                       input logic flush);
    v_valid = valid; v_rs1 = AW'(rs1); v_use1 = use1; v_rs2 = AW'(rs2); v_use2 = use2;
    v_we = we; v_rd = AW'(rd); v_lat = CW'(lat); v_flush = flush;
  endtask

  task automatic idle();
    drive(0, 0, 0, 0, 0, 0, 0, 0, 0);
  endtask

  task automatic write_reg(input int rd, input int lat);
    drive(1, 0, 0, 0, 0, 1, rd, lat, 0);
  endtask

  task automatic read_reg(input int rs, input logic flush);
    drive(1, rs, 1, 0, 0, 0, 0, 1, flush);
  endtask

  initial begin
    reset = 1'b1;
    idle();
    tick(); tick();

    // Reset over stale state with an issue present.
    reset = 1'b0;
    write_reg(3, 4); tick();
    write_reg(9, 2); tick();
    reset = 1'b1;
    write_reg(4, 3); tick();
    reset = 1'b0;
    idle();
    @(negedge clk);
    for (int k = 0; k < 2; k++) begin
      check($sformatf("rst_busy[%0d]", k), 64'(o_busy[k]), 64'd0);
      check($sformatf("rst_scnt[%0d]", k), 64'(o_scnt[k]), 64'd0);
      check($sformatf("rst_stall[%0d]", k), 64'(o_stall[k]), 64'd0);
    end

    // RAW on x5 (lat 2): bypass fires one cycle earlier than no-bypass.
    tick();
    write_reg(5, 2); tick();
    read_reg(5, 0);
    @(negedge clk);
    check("raw_t1_stall0", 64'(o_stall[0]), 64'd1);
    check("raw_t1_stall1", 64'(o_stall[1]), 64'd1);
    tick();
    @(negedge clk);
    check("raw_t2_fire0", 64'(o_fire[0]), 64'd1);
    check("raw_t2_fwd0", 64'(o_fwd1[0]), 64'd1);
    check("raw_t2_stall1", 64'(o_stall[1]), 64'd1);
    tick();
    @(negedge clk);
    check("raw_t3_fire1", 64'(o_fire[1]), 64'd1);
    check("raw_t3_fwd1", 64'(o_fwd1[1]), 64'd0);
    tick();
    idle();
    @(negedge clk);
    check("raw_scnt0", 64'(o_scnt[0]), 64'd1);
    check("raw_scnt1", 64'(o_scnt[1]), 64'd2);

    // WAW on x7: lat 4 in flight, new lat 1 write waits until cnt[7] == 1.
    tick();
    write_reg(7, 4); tick();
    write_reg(7, 1);
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      check($sformatf("waw_stall_%0d", i), 64'(o_stall[0]), 64'd1);
      tick();
    end
    @(negedge clk);
    check("waw_fire", 64'(o_fire[0]), 64'd1);
    tick();
    idle();
    @(negedge clk);
    check("waw_busy7_set", 64'(o_busy[0][7]), 64'd1);
    tick();
    @(negedge clk);
    check("waw_busy7_clr", 64'(o_busy[0][7]), 64'd0);

    // rd = 0 never tracked; x0 reads never hazard.
    write_reg(0, 4); tick();
    drive(1, 0, 1, 0, 1, 0, 0, 1, 0);
    @(negedge clk);
    check("x0_busy", 64'(o_busy[0]), 64'd0);
    check("x0_fire", 64'(o_fire[0]), 64'd1);
    tick();

    // Latency clamp: 0 behaves as 1, 7 clamps to MAX_LAT.
    write_reg(10, 0); tick();
    idle();
    @(negedge clk);
    check("lat0_busy", 64'(o_busy[0][10]), 64'd1);
    tick();
    @(negedge clk);
    check("lat0_clr", 64'(o_busy[0][10]), 64'd0);
    write_reg(11, 7); tick();
    idle();
    for (int i = 0; i < 4; i++) begin
      @(negedge clk);
      check($sformatf("lat7_busy_%0d", i), 64'(o_busy[0][11]), 64'd1);
      tick();
    end
    @(negedge clk);
    check("lat7_clr", 64'(o_busy[0][11]), 64'd0);

    // Flush cancels a hazarded issue; counters keep draining.
    write_reg(12, 4); tick();
    read_reg(12, 1);
    @(negedge clk);
    check("flush_stall", 64'(o_stall[0]), 64'd0);
    check("flush_fire", 64'(o_fire[0]), 64'd0);
    tick();
    read_reg(12, 0);
    @(negedge clk);
    check("post_flush_stall", 64'(o_stall[0]), 64'd1);
    tick();
    idle();
    for (int i = 0; i < 4; i++) tick();

    // Randomized traffic over a small register window to provoke hazards.
    for (int i = 0; i < 3000; i++) begin
      reset = ($urandom_range(0, 199) == 0);
      drive($urandom_range(0, 3) != 0,
            int'($urandom_range(0, 7)), 1'($urandom_range(0, 1)),
            int'($urandom_range(0, 7)), 1'($urandom_range(0, 1)),
            1'($urandom_range(0, 1)), int'($urandom_range(0, 7)),
            int'($urandom_range(0, 7)), $urandom_range(0, 7) == 0);
      tick();
    end
    reset = 1'b0;
    idle();
    tick();

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
